// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared 800x600@60 timing constants, counter widths and sync polarity.
// Used by the timing generator and by the downstream RGB fetch stage so both
// agree on the visible-area bounds.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int H_VIS   = 800;
    localparam int H_FP    = 40;
    localparam int H_SYNC  = 128;
    localparam int H_BP    = 88;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;  // 1056

    localparam int V_VIS   = 600;
    localparam int V_FP    = 1;
    localparam int V_SYNC  = 4;
    localparam int V_BP    = 23;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;  // 628

    localparam int H_CNT_W = 11;
    localparam int V_CNT_W = 10;

    // 800x600@60 uses positive-going sync pulses.
    localparam bit SYNC_POL = 1'b1;

    typedef logic [H_CNT_W-1:0] hcnt_t;
    typedef logic [V_CNT_W-1:0] vcnt_t;

    // Signals that travel together through the alignment delay line.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } sync_bus_t;

endpackage

// File: rtl/sig_delay_line.sv
// -----------------------------------------------------------------------------
// sig_delay_line
// Fixed-depth shift register with asynchronous reset to INIT.
// DEPTH = 0 is a straight wire (q_o follows d_i).
//
// Ports:
//   clk   in   clock
//   rst   in   asynchronous, active-high reset; all stages load INIT
//   d_i   in   W-bit input
//   q_o   out  W-bit input delayed by DEPTH clk
// -----------------------------------------------------------------------------
module sig_delay_line #(
    parameter int             W     = 1,
    parameter int             DEPTH = 1,
    parameter logic [W-1:0]   INIT  = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    if (DEPTH == 0) begin : g_bypass
        assign q_o = d_i;
    end else begin : g_pipe
        logic [W-1:0] pipe_q [DEPTH];

        // NOTE: every stage is reset, not just the last one; otherwise stale
        // sync levels from before reset would walk out after release.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) pipe_q[i] <= INIT;
            end else begin
                pipe_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign q_o = pipe_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Pixel-timing generator for the 800x600 video path. Produces the horizontal
// and vertical counters used by the RGB fetch stage to address pixel RAM, plus
// hsync/vsync/video_on delayed by SYNC_DELAY clk to match that stage's latency.
//
// Ports:
//   clk              in   pixel clock
//   rst              in   asynchronous, active-high reset
//   count_rgb        out  horizontal counter, 0..H_TOTAL-1
//   reset_count_rgb  out  vertical counter, 0..V_TOTAL-1
//   hsync            out  horizontal sync (level SYNC_POL when active)
//   vsync            out  vertical sync (level SYNC_POL when active)
//   video_on         out  visible-area flag
//   line_start       out  high while count_rgb == 0
//   frame_start      out  high while count_rgb == 0 and reset_count_rgb == 0
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VIS      = vga_timing_pkg::H_VIS,
    parameter int H_FP       = vga_timing_pkg::H_FP,
    parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int H_BP       = vga_timing_pkg::H_BP,
    parameter int V_VIS      = vga_timing_pkg::V_VIS,
    parameter int V_FP       = vga_timing_pkg::V_FP,
    parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int V_BP       = vga_timing_pkg::V_BP,
    parameter bit SYNC_POL   = vga_timing_pkg::SYNC_POL,
    parameter int SYNC_DELAY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output vga_timing_pkg::hcnt_t  count_rgb,
    output vga_timing_pkg::vcnt_t  reset_count_rgb,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   video_on,
    output logic                   line_start,
    output logic                   frame_start
);

    typedef vga_timing_pkg::hcnt_t     hcnt_t;
    typedef vga_timing_pkg::vcnt_t     vcnt_t;
    typedef vga_timing_pkg::sync_bus_t sync_bus_t;

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
    end
    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1)
    begin : g_bad_porch
        $error("vga_timing_gen: every porch and sync width must be >= 1");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 8) begin : g_bad_delay
        $error("vga_timing_gen: SYNC_DELAY must be within 0..8");
    end

    localparam hcnt_t H_LAST   = hcnt_t'(H_TOTAL - 1);
    localparam hcnt_t H_VIS_C  = hcnt_t'(H_VIS);
    localparam hcnt_t HS_FIRST = hcnt_t'(H_VIS + H_FP);
    localparam hcnt_t HS_LAST  = hcnt_t'(H_VIS + H_FP + H_SYNC - 1);
    localparam vcnt_t V_LAST   = vcnt_t'(V_TOTAL - 1);
    localparam vcnt_t V_VIS_C  = vcnt_t'(V_VIS);
    localparam vcnt_t VS_FIRST = vcnt_t'(V_VIS + V_FP);
    localparam vcnt_t VS_LAST  = vcnt_t'(V_VIS + V_FP + V_SYNC - 1);

    localparam sync_bus_t IDLE = '{hsync: !SYNC_POL, vsync: !SYNC_POL, video_on: 1'b0};

    hcnt_t     h_q, h_d;
    vcnt_t     v_q, v_d;
    sync_bus_t raw_q, raw_d;
    logic      line_start_q, frame_start_q;
    sync_bus_t sync_dly;

    // Decodes are taken from the next-state counters so that raw_q is already
    // registered and aligned with h_q/v_q; the delay line then adds exactly
    // SYNC_DELAY on top.
    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        h_d = h_q + hcnt_t'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + vcnt_t'(1);
        end

        raw_d.hsync    = (h_d >= HS_FIRST && h_d <= HS_LAST) ? SYNC_POL : !SYNC_POL;
        raw_d.vsync    = (v_d >= VS_FIRST && v_d <= VS_LAST) ? SYNC_POL : !SYNC_POL;
        raw_d.video_on = (h_d < H_VIS_C) && (v_d < V_VIS_C);
    end

    // Reset parks the counters on the last pixel so the first edge after
    // release lands on (0,0) and raises line_start/frame_start immediately.
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q           <= H_LAST;
            v_q           <= V_LAST;
            raw_q         <= IDLE;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            raw_q         <= raw_d;
            line_start_q  <= (h_d == '0);
            frame_start_q <= (h_d == '0) && (v_d == '0);
        end
    end

    sig_delay_line #(
        .W     (3),
        .DEPTH (SYNC_DELAY),
        .INIT  (IDLE)
    ) u_sync_dly (
        .clk (clk),
        .rst (rst),
        .d_i (raw_q),
        .q_o (sync_dly)
    );

    assign count_rgb       = h_q;
    assign reset_count_rgb = v_q;
    assign hsync           = sync_dly.hsync;
    assign vsync           = sync_dly.vsync;
    assign video_on        = sync_dly.video_on;
    assign line_start      = line_start_q;
    assign frame_start     = frame_start_q;

endmodule
